prism_sp_acp_cmd_queue: RTL
===========================

PRISM_SP_ACP_CMD_QUEUE -- requirements
Module: prism_sp_acp_cmd_queue

Interface
REQ-001 Parameters SHALL be: NCHAN=2 (number of command channels, 1..8); DEPTH=4 (entries per channel FIFO, power of two, 2..16); ACPRAM_ADDR_WIDTH=20; AXI_ADDR_WIDTH=40.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  clock
- resetn  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_chan  in  $clog2(NCHAN) (min 1)  target channel
- cmd_write  in  1  1 = ACP write, 0 = ACP read
- cmd_len  in  1  0 = 16-byte, 1 = 64-byte transfer
- cmd_acpram_addr  in  ACPRAM_ADDR_WIDTH  local word address
- cmd_axi_addr  in  AXI_ADDR_WIDTH  remote byte address
- eng_start  out  1  one-cycle start pulse to ACP engine
- eng_write, eng_len, eng_acpram_addr, eng_axi_addr  out  1/1/ACPRAM_ADDR_WIDTH/AXI_ADDR_WIDTH  command to engine, stable from eng_start until completion
- eng_busy  in  1  engine busy
- flush  in  NCHAN  per-channel synchronous flush
- chan_pending  out  NCHAN x ($clog2(DEPTH)+1)  queued plus in-flight count per channel
- chan_done  out  NCHAN x 16  completed-transfer counter per channel
- chan_align_err  out  NCHAN  sticky misaligned-command flag
- err_clear  in  NCHAN  clears chan_align_err
REQ-003 Clock SHALL be clk; reset SHALL be resetn, asynchronous assert, active-low, single clock domain.

Function
REQ-004 Each channel SHALL own a DEPTH-entry FIFO holding {write, len, acpram_addr, axi_addr}.
REQ-005 cmd_ready SHALL be combinationally high iff the FIFO selected by cmd_chan is not full; cmd_chan >= NCHAN SHALL give cmd_ready=0.
REQ-006 Alignment: cmd_axi_addr[3:0] must be 0 (len=0) or cmd_axi_addr[5:0] must be 0 and cmd_acpram_addr[1:0] must be 0 (len=1); a misaligned accepted handshake SHALL NOT enqueue and SHALL set chan_align_err[cmd_chan] next cycle.
REQ-007 err_clear[i] SHALL clear chan_align_err[i]; simultaneous set and clear SHALL leave it set.
REQ-008 Dispatcher FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-009 IDLE: if any FIFO non-empty, grant round-robin starting at channel (last_grant+1) mod NCHAN, pop its head into the eng_* registers, go to START.
REQ-010 START: eng_start=1 for exactly this cycle; go to WAIT_BUSY.
REQ-011 WAIT_BUSY: on eng_busy=1 go to WAIT_DONE; if eng_busy stays 0 for 2 cycles after START, treat the transfer as complete and go to IDLE (zero-latency engine).
REQ-012 WAIT_DONE: on eng_busy=0 the transfer SHALL complete: chan_done[granted] increments (wraps 0xFFFF->0), FSM returns to IDLE.
REQ-013 Minimum command-to-command spacing SHALL be: dequeue in IDLE, START next cycle; back-to-back dispatch permitted from IDLE the cycle after completion.
REQ-014 chan_pending[i] SHALL equal FIFO occupancy plus 1 while channel i's command is in START/WAIT_BUSY/WAIT_DONE.
REQ-015 flush[i] SHALL empty FIFO i in one cycle; an in-flight command of channel i SHALL still complete and count; enqueue to channel i in the flush cycle SHALL be dropped and cmd_ready for channel i SHALL be 0 that cycle.
REQ-016 Enqueue and dequeue on the same FIFO in one cycle SHALL both take effect; a full FIFO SHALL accept a push only if not full at the start of the cycle.
REQ-017 FIFO pointers SHALL wrap modulo DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-018 On resetn=0: FSM=IDLE, all FIFOs empty, eng_start=0, eng_* command registers=0, chan_done=0, chan_align_err=0, last_grant=NCHAN-1 (so channel 0 is first), chan_pending=0.
REQ-019 Reset mid-transfer SHALL abandon the in-flight command without counting it.

Verification
REQ-020 Push read len=1 axi 0x40 acpram 0x4 on ch0; eng_busy high 3 cycles -> eng_start pulses once 2 cycles after push, chan_done[0]=1, chan_pending[0]=0.
REQ-021 Fill ch1 with DEPTH commands -> cmd_ready=0 for ch1 while ch0 still accepts; each completion reopens one slot.
REQ-022 Push ch0 and ch1 simultaneously backlogged (3 each) -> dispatch order ch0,ch1,ch0,ch1,ch0,ch1.
REQ-023 Push len=1 axi 0x20 on ch1 -> nothing enqueued, chan_align_err[1]=1; err_clear[1] -> 0.
REQ-024 flush[0] with 3 queued, 1 in flight -> chan_pending[0]=1 next cycle, chan_done[0] increments by exactly 1.
REQ-025 Deassert resetn during WAIT_DONE -> all outputs at REQ-018 values, chan_done unchanged at 0.

Source files
------------

// File: rtl/prism_sp_acp_cmd_queue.sv
// Per-channel ACP command FIFOs feeding one ACP engine through a round-robin dispatcher.
// The dispatcher also tracks completions, alignment errors and per-channel flushes.
module prism_sp_acp_cmd_queue #(
  parameter int unsigned NCHAN             = 2,
  parameter int unsigned DEPTH             = 4,
  parameter int unsigned ACPRAM_ADDR_WIDTH = 20,
  parameter int unsigned AXI_ADDR_WIDTH    = 40,
  localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int unsigned PW = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [CW-1:0]                       cmd_chan,
  input  logic                                cmd_write,
  input  logic                                cmd_len,
  input  logic [ACPRAM_ADDR_WIDTH-1:0]        cmd_acpram_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]           cmd_axi_addr,
  output logic                                eng_start,
  output logic                                eng_write,
  output logic                                eng_len,
  output logic [ACPRAM_ADDR_WIDTH-1:0]        eng_acpram_addr,
  output logic [AXI_ADDR_WIDTH-1:0]           eng_axi_addr,
  input  logic                                eng_busy,
  input  logic [NCHAN-1:0]                    flush,
  output logic [NCHAN-1:0][PW-1:0]            chan_pending,
  output logic [NCHAN-1:0][15:0]              chan_done,
  output logic [NCHAN-1:0]                    chan_align_err,
  input  logic [NCHAN-1:0]                    err_clear
);

  localparam int unsigned AW = PW - 1;

  typedef struct packed {
    logic                         write;
    logic                         len;
    logic [ACPRAM_ADDR_WIDTH-1:0] acpram_addr;
    logic [AXI_ADDR_WIDTH-1:0]    axi_addr;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  cmd_t                      mem [NCHAN][DEPTH];
  logic [NCHAN-1:0][PW-1:0]  wr_ptr, rd_ptr, occ;
  logic [NCHAN-1:0]          full, nonempty, push, pop;
  state_t                    state;
  logic [CW-1:0]             last_grant;
  logic                      quiet;
  logic                      sel_ok, sel_full, sel_flush;
  logic                      aligned, accept, push_en, grant_vld;
  logic [CW-1:0]             grant_idx, rr_idx;
  cmd_t                      head, cmd_in;

  assign cmd_in = '{write: cmd_write, len: cmd_len,
                    acpram_addr: cmd_acpram_addr, axi_addr: cmd_axi_addr};

  // FIFO status; pointers carry one extra wrap bit
  always_comb begin
    occ      = '0;
    full     = '0;
    nonempty = '0;
    for (int i = 0; i < NCHAN; i++) begin
      occ[i]      = wr_ptr[i] - rd_ptr[i];
      full[i]     = (occ[i] == PW'(DEPTH));
      nonempty[i] = (occ[i] != '0);
    end
  end

  // Enqueue side: readiness is judged on start-of-cycle occupancy
  always_comb begin
    sel_ok    = 1'b0;
    sel_full  = 1'b0;
    sel_flush = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (cmd_chan == CW'(i)) begin
        sel_ok    = 1'b1;
        sel_full  = full[i];
        sel_flush = flush[i];
      end
    end
    cmd_ready = sel_ok && !sel_full && !sel_flush;
    aligned   = cmd_len ? ((cmd_axi_addr[5:0] == 6'd0) && (cmd_acpram_addr[1:0] == 2'd0))
                        : (cmd_axi_addr[3:0] == 4'd0);
    accept    = cmd_valid && cmd_ready;
    push_en   = accept && aligned;
    push      = '0;
    for (int i = 0; i < NCHAN; i++) begin
      push[i] = push_en && (cmd_chan == CW'(i));
    end
  end

  // Round-robin grant starting after the last granted channel; flushing channels are skipped
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int k = 0; k < NCHAN; k++) begin
      rr_idx = CW'((int'(last_grant) + 1 + k) % int'(NCHAN));
      if (!grant_vld && nonempty[rr_idx] && !flush[rr_idx]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx;
      end
    end
    pop = '0;
    for (int i = 0; i < NCHAN; i++) begin
      pop[i] = (state == IDLE) && grant_vld && (grant_idx == CW'(i));
    end
    head = mem[grant_idx][rd_ptr[grant_idx][AW-1:0]];
  end

  always_comb begin
    chan_pending = '0;
    for (int i = 0; i < NCHAN; i++) begin
      chan_pending[i] = occ[i] + PW'((state != IDLE) && (last_grant == CW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= cmd_in;
    end
  end

  // Pointers and sticky alignment errors (set wins over clear)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      chan_align_err <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (flush[i]) begin
          rd_ptr[i] <= wr_ptr[i];
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
        if (accept && !aligned && (cmd_chan == CW'(i))) chan_align_err[i] <= 1'b1;
        else if (err_clear[i])                          chan_align_err[i] <= 1'b0;
      end
    end
  end

  // Dispatcher; an engine that never raises busy completes after two quiet cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      last_grant      <= CW'(NCHAN - 1);
      quiet           <= 1'b0;
      eng_start       <= 1'b0;
      eng_write       <= 1'b0;
      eng_len         <= 1'b0;
      eng_acpram_addr <= '0;
      eng_axi_addr    <= '0;
      chan_done       <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            eng_write       <= head.write;
            eng_len         <= head.len;
            eng_acpram_addr <= head.acpram_addr;
            eng_axi_addr    <= head.axi_addr;
            last_grant      <= grant_idx;
            eng_start       <= 1'b1;
            state           <= START;
          end
        end
        START: begin
          quiet <= 1'b0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (eng_busy) begin
            state <= WAIT_DONE;
          end else if (quiet) begin
            chan_done[last_grant] <= chan_done[last_grant] + 16'd1;
            state                 <= IDLE;
          end else begin
            quiet <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!eng_busy) begin
            chan_done[last_grant] <= chan_done[last_grant] + 16'd1;
            state                 <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
